// File: rtl/arp_packet_tx.sv
// ARP payload serialiser: captures opcode/target fields on start and streams the
// 28-byte ARP payload (optionally zero-padded to 46 bytes) as byte or nibble beats.
module arp_packet_tx #(
  parameter int unsigned DATA_W   = 8,
  parameter logic [47:0] MAC_ADDR = 48'h0,
  parameter logic [31:0] IP_ADDR  = 32'h0,
  parameter bit          PAD_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_reply,
  input  logic [47:0]       tha,
  input  logic [31:0]       tpa,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PAYLOAD_BYTES = PAD_EN ? 46 : 28;
  localparam int unsigned NUM_BEATS     = PAYLOAD_BYTES * 8 / DATA_W;
  localparam int unsigned CNT_W         = $clog2(92);
  localparam int unsigned ARP_BITS      = 224;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  if (DATA_W != 8 && DATA_W != 4) begin : g_bad_width
    $error("arp_packet_tx: DATA_W must be 4 or 8");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                op_q;
  logic [47:0]         tha_q;
  logic [31:0]         tpa_q;

  logic [ARP_BITS-1:0] payload;
  logic [ARP_BITS-1:0] shifted;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [CNT_W-1:0]    byte_idx;
  logic [7:0]          cur_byte;
  logic [DATA_W-1:0]   data_nxt;

  // Beat value for cnt+1; byte offsets past 27 shift out to zero, giving the pad bytes.
  always_comb begin
    payload  = {16'h0001, 16'h0800, 8'h06, 8'h04, 14'h0, op_q, ~op_q,
                MAC_ADDR, IP_ADDR, (op_q ? tha_q : 48'h0), tpa_q};
    cnt_nxt  = cnt + CNT_W'(1);
    byte_idx = (DATA_W == 8) ? cnt_nxt : (cnt_nxt >> 1);
    shifted  = payload << {byte_idx, 3'b000};
    cur_byte = shifted[ARP_BITS-1 -: 8];
    if (DATA_W == 8) begin
      data_nxt = DATA_W'(cur_byte);
    end else begin
      // MII order: low nibble first
      data_nxt = DATA_W'(cnt_nxt[0] ? cur_byte[7:4] : cur_byte[3:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= 1'b0;
      tha_q   <= '0;
      tpa_q   <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op_reply;
            tha_q   <= tha;
            tpa_q   <= tpa;
            cnt     <= '0;
            state   <= SEND;
            m_valid <= 1'b1;
            busy    <= 1'b1;
            m_data  <= '0;
            m_last  <= 1'b0;
          end
        end
        SEND: begin
          if (m_ready) begin
            if (cnt == LAST_BEAT) begin
              state   <= IDLE;
              m_valid <= 1'b0;
              busy    <= 1'b0;
              m_last  <= 1'b0;
              m_data  <= '0;
              done    <= 1'b1;
            end else begin
              cnt    <= cnt_nxt;
              m_data <= data_nxt;
              m_last <= (cnt_nxt == LAST_BEAT);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_packet_tx.sv
// Scoreboard bench for arp_packet_tx: byte/no-pad and nibble/pad instances checked
// against an independently built golden beat stream.
module tb_arp_packet_tx;

  localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;
  localparam logic [31:0] IP  = 32'hC0_A8_01_0A;

  typedef struct {
    logic [7:0] d;
    bit         last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0, start4 = 1'b0;
  logic        op_reply = 1'b0;
  logic [47:0] tha = '0;
  logic [31:0] tpa = '0;
  logic        ready8 = 1'b1, ready4 = 1'b1;
  logic [7:0]  m_data8;
  logic [3:0]  m_data4;
  logic        m_valid8, m_valid4, m_last8, m_last4, busy8, busy4, done8, done4;

  beat_t q8[$];
  beat_t q4[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    hs8 = 0, hs4 = 0;
  bit    dn8 = 1'b0, dn4 = 1'b0;
  bit    pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  arp_packet_tx #(.DATA_W(8), .MAC_ADDR(MAC), .IP_ADDR(IP), .PAD_EN(1'b0)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op_reply(op_reply), .tha(tha), .tpa(tpa),
    .m_data(m_data8), .m_valid(m_valid8), .m_ready(ready8), .m_last(m_last8),
    .busy(busy8), .done(done8));

  arp_packet_tx #(.DATA_W(4), .MAC_ADDR(MAC), .IP_ADDR(IP), .PAD_EN(1'b1)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op_reply(op_reply), .tha(tha), .tpa(tpa),
    .m_data(m_data4), .m_valid(m_valid4), .m_ready(ready4), .m_last(m_last4),
    .busy(busy4), .done(done4));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Golden stream built byte by byte from the ARP field layout
  task automatic push_pkt(input bit w4, input bit op, input logic [47:0] t_ha,
                          input logic [31:0] t_pa);
    logic [7:0] b[$];
    beat_t      e;
    b = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, (op ? 8'h02 : 8'h01)};
    for (int i = 5; i >= 0; i--) b.push_back(MAC[8*i +: 8]);
    for (int i = 3; i >= 0; i--) b.push_back(IP[8*i +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(op ? t_ha[8*i +: 8] : 8'h00);
    for (int i = 3; i >= 0; i--) b.push_back(t_pa[8*i +: 8]);
    if (w4) for (int i = 0; i < 18; i++) b.push_back(8'h00);
    for (int i = 0; i < b.size(); i++) begin
      if (w4) begin
        e.d = {4'h0, b[i][3:0]}; e.last = 1'b0; q4.push_back(e);
        e.d = {4'h0, b[i][7:4]}; e.last = (i == b.size() - 1); q4.push_back(e);
      end else begin
        e.d = b[i]; e.last = (i == b.size() - 1); q8.push_back(e);
      end
    end
  endtask

  // Call at posedge+1; start is sampled at the next edge
  task automatic send(input bit w4, input bit op, input logic [47:0] t_ha,
                      input logic [31:0] t_pa);
    op_reply = op; tha = t_ha; tpa = t_pa;
    if (w4) start4 = 1'b1; else start8 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; start8 = 1'b0;
    if (w4) begin
      chk("latency_valid4", {7'h0, m_valid4}, 8'h01);
      hs4 = 0;
    end else begin
      chk("latency_valid8", {7'h0, m_valid8}, 8'h01);
      hs8 = 0;
    end
    push_pkt(w4, op, t_ha, t_pa);
  endtask

  task automatic run_until_done(input bit w4, input bit toggle);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (w4) ready4 = toggle ? pat[i % 5] : 1'b1;
      else    ready8 = toggle ? pat[i % 5] : 1'b1;
      @(posedge clk); #1;
      if (w4 ? done4 : done8) begin ok = 1'b1; break; end
    end
    ready4 = 1'b1; ready8 = 1'b1;
    chk(w4 ? "done_timeout4" : "done_timeout8", {7'h0, ok}, 8'h01);
    if (w4) chk("handshakes4", 8'(hs4), 8'd92);
    else    chk("handshakes8", 8'(hs8), 8'd28);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete(); dn8 = 1'b0;
    end else begin
      chk("done8", {7'h0, done8}, {7'h0, dn8});
      dn8 = 1'b0;
      chk("busy8", {7'h0, busy8}, {7'h0, q8.size() > 0});
      if (q8.size() > 0) begin
        chk("valid8", {7'h0, m_valid8}, 8'h01);
        chk("data8", m_data8, q8[0].d);
        chk("last8", {7'h0, m_last8}, {7'h0, q8[0].last});
        if (m_valid8 && ready8) begin
          dn8 = q8[0].last;
          void'(q8.pop_front());
          hs8++;
        end
      end else begin
        chk("idle_valid8", {7'h0, m_valid8}, 8'h00);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q4.delete(); dn4 = 1'b0;
    end else begin
      chk("done4", {7'h0, done4}, {7'h0, dn4});
      dn4 = 1'b0;
      chk("busy4", {7'h0, busy4}, {7'h0, q4.size() > 0});
      if (q4.size() > 0) begin
        chk("valid4", {7'h0, m_valid4}, 8'h01);
        chk("data4", {4'h0, m_data4}, q4[0].d);
        chk("last4", {7'h0, m_last4}, {7'h0, q4[0].last});
        if (m_valid4 && ready4) begin
          dn4 = q4[0].last;
          void'(q4.pop_front());
          hs4++;
        end
      end else begin
        chk("idle_valid4", {7'h0, m_valid4}, 8'h00);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid8", {7'h0, m_valid8}, 8'h00);
    chk("rst_last8", {7'h0, m_last8}, 8'h00);
    chk("rst_busy8", {7'h0, busy8}, 8'h00);
    chk("rst_done8", {7'h0, done8}, 8'h00);
    chk("rst_data8", m_data8, 8'h00);
    chk("rst_data4", {4'h0, m_data4}, 8'h00);
    chk("rst_valid4", {7'h0, m_valid4}, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reply and request, byte width, full rate
    send(1'b0, 1'b1, 48'hAABBCCDDEEFF, 32'hC0A80101);
    run_until_done(1'b0, 1'b0);
    send(1'b0, 1'b0, 48'hAABBCCDDEEFF, 32'hC0A80101);
    run_until_done(1'b0, 1'b0);

    // Nibble width with padding
    send(1'b1, 1'b1, 48'hAABBCCDDEEFF, 32'hC0A80101);
    run_until_done(1'b1, 1'b0);

    // Backpressure pattern on both widths
    send(1'b0, 1'b1, 48'h112233445566, 32'h0A000001);
    run_until_done(1'b0, 1'b1);
    send(1'b1, 1'b0, 48'h112233445566, 32'h0A000001);
    run_until_done(1'b1, 1'b1);

    // Mid-packet start and field change ignored; back-to-back start in done cycle
    send(1'b0, 1'b1, 48'hAABBCCDDEEFF, 32'hC0A80101);
    repeat (5) begin @(posedge clk); #1; end
    tha = 48'h0123456789AB; tpa = 32'h01020304; op_reply = 1'b0;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    run_until_done(1'b0, 1'b0);
    send(1'b0, 1'b1, 48'h0123456789AB, 32'h01020304);
    run_until_done(1'b0, 1'b0);

    // Reset while beat 10 is presented
    send(1'b0, 1'b1, 48'hAABBCCDDEEFF, 32'hC0A80101);
    repeat (10) begin @(posedge clk); #1; end
    chk("pre_rst_data8", m_data8, 8'h00);
    chk("pre_rst_beat10", {7'h0, m_valid8}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid8", {7'h0, m_valid8}, 8'h00);
    chk("midrst_busy8", {7'h0, busy8}, 8'h00);
    chk("midrst_done8", {7'h0, done8}, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    send(1'b0, 1'b1, 48'hAABBCCDDEEFF, 32'hC0A80101);
    chk("post_rst_beat0", m_data8, 8'h00);
    run_until_done(1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("q8_drained", 8'(q8.size()), 8'h00);
    chk("q4_drained", 8'(q4.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
